// File: rtl/eka_mem_arbiter.sv
// eka_mem_arbiter: shares one single-ported memory between the instruction-fetch
// port and the data port. One transaction is outstanding at a time; the data port
// has fixed priority, and a starvation counter guarantees that fetch makes progress.
module eka_mem_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    // instruction-fetch port
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [31:0]           if_rdata,
    // data port
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [31:0]           d_wdata,
    input  logic [3:0]            d_be,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [31:0]           d_rdata,
    // memory port
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [3:0]            mem_be,
    input  logic                  mem_rvalid,
    input  logic [31:0]           mem_rdata
);

    typedef enum logic {IDLE, BUSY} state_t;
    typedef enum logic {OWN_IF, OWN_D} owner_t;

    localparam logic [3:0] STARVE_MAX = 4'd15;
    localparam logic [3:0] LIMIT      = 4'(STARVE_LIMIT);

    state_t     state;
    owner_t     owner;
    logic [3:0] starve_cnt;

    logic if_wins;
    logic d_wins;
    logic issue;
    logic resp;

    // Arbitration: data wins a tie unless fetch has lost LIMIT times in a row.
    // Everything is gated by reset so the outputs are quiet while reset is held.
    always_comb begin
        if_wins = if_req && (!d_req || (starve_cnt >= LIMIT));
        d_wins  = d_req && !if_wins;
        issue   = !reset && (state == IDLE) && (if_req || d_req);
        resp    = !reset && (state == BUSY) && mem_rvalid;
    end

    // Memory request mux and response routing back to the owning port.
    always_comb begin
        // NOTE: every output gets a default first so no path through the block
        // leaves a signal unassigned, which would otherwise infer a latch.
        mem_req   = issue;
        if_gnt    = issue && if_wins;
        d_gnt     = issue && d_wins;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = 4'h0;
        if (if_gnt) begin
            mem_addr = if_addr;
            mem_be   = 4'hF;
        end else if (d_gnt) begin
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            mem_be    = d_be;
        end
        if_rvalid = resp && (owner == OWN_IF);
        d_rvalid  = resp && (owner == OWN_D);
        if_rdata  = if_rvalid ? mem_rdata : 32'h0;
        d_rdata   = d_rvalid  ? mem_rdata : 32'h0;
    end

    // Transaction state, owner and fetch starvation counter.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state registers use non-blocking assignments so every register
        // samples the values from before the edge, independent of statement order.
        if (reset) begin
            state      <= IDLE;
            owner      <= OWN_IF;
            starve_cnt <= 4'd0;
        end else if (state == IDLE) begin
            if (if_req || d_req) begin
                state <= BUSY;
                owner <= if_wins ? OWN_IF : OWN_D;
            end
            if (if_wins) begin
                starve_cnt <= 4'd0;
            end else if (if_req && (starve_cnt != STARVE_MAX)) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end else begin
            if (mem_rvalid) begin
                state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_eka_mem_arbiter.sv
// Testbench for eka_mem_arbiter: directed scenarios with literal expectations,
// then randomized traffic against a transaction-level reference model.
module tb_eka_mem_arbiter;

    localparam int AW    = 32;
    localparam int LIMIT = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [31:0]   if_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [31:0]   d_wdata;
    logic [3:0]    d_be;
    logic          d_gnt;
    logic          d_rvalid;
    logic [31:0]   d_rdata;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_be;
    logic          mem_rvalid;
    logic [31:0]   mem_rdata;

    eka_mem_arbiter #(.ADDR_WIDTH(AW), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: is a transaction outstanding, who owns it, and how many
    // arbitrations in a row has fetch lost.
    bit m_outstanding;
    bit m_owner_is_fetch;
    int m_losses;
    bit n_outstanding;
    bit n_owner_is_fetch;
    int n_losses;

    logic          e_mem_req, e_if_gnt, e_d_gnt, e_if_rvalid, e_d_rvalid, e_mem_we;
    logic [31:0]   e_if_rdata, e_d_rdata, e_mem_wdata;
    logic [AW-1:0] e_mem_addr;
    logic [3:0]    e_mem_be;

    int mem_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Mid-cycle: derive what the outputs must be from the model and the current
    // inputs, compare every output, and compute the model's next state.
    task automatic settle();
        bit fetch_wins;
        bit chk_fields;
        #4;
        e_mem_req = 0; e_if_gnt = 0; e_d_gnt = 0; e_if_rvalid = 0; e_d_rvalid = 0;
        e_mem_we = 0; e_if_rdata = 0; e_d_rdata = 0; e_mem_wdata = 0; e_mem_addr = 0;
        e_mem_be = 0;
        n_outstanding = m_outstanding;
        n_owner_is_fetch = m_owner_is_fetch;
        n_losses = m_losses;
        chk_fields = 1;
        if (reset) begin
            n_outstanding = 0;
            n_owner_is_fetch = 0;
            n_losses = 0;
        end else if (!m_outstanding) begin
            if (if_req || d_req) begin
                fetch_wins = if_req && (!d_req || m_losses >= LIMIT);
                e_mem_req = 1;
                if (fetch_wins) begin
                    e_if_gnt = 1;
                    e_mem_addr = if_addr;
                    e_mem_be = 4'hF;
                    n_losses = 0;
                end else begin
                    e_d_gnt = 1;
                    e_mem_we = d_we;
                    e_mem_addr = d_addr;
                    e_mem_wdata = d_wdata;
                    e_mem_be = d_be;
                    if (if_req) n_losses = (m_losses < 15) ? m_losses + 1 : 15;
                end
                n_outstanding = 1;
                n_owner_is_fetch = fetch_wins;
            end
        end else begin
            chk_fields = 0;
            if (mem_rvalid) begin
                if (m_owner_is_fetch) begin
                    e_if_rvalid = 1;
                    e_if_rdata = mem_rdata;
                end else begin
                    e_d_rvalid = 1;
                    e_d_rdata = mem_rdata;
                end
                n_outstanding = 0;
            end
        end
        check("mem_req", 32'(mem_req), 32'(e_mem_req));
        check("if_gnt", 32'(if_gnt), 32'(e_if_gnt));
        check("d_gnt", 32'(d_gnt), 32'(e_d_gnt));
        check("if_rvalid", 32'(if_rvalid), 32'(e_if_rvalid));
        check("d_rvalid", 32'(d_rvalid), 32'(e_d_rvalid));
        check("if_rdata", if_rdata, e_if_rdata);
        check("d_rdata", d_rdata, e_d_rdata);
        if (chk_fields) begin
            check("mem_we", 32'(mem_we), 32'(e_mem_we));
            check("mem_addr", mem_addr, e_mem_addr);
            check("mem_wdata", mem_wdata, e_mem_wdata);
            check("mem_be", 32'(mem_be), 32'(e_mem_be));
        end
    endtask

    task automatic advance();
        m_outstanding = n_outstanding;
        m_owner_is_fetch = n_owner_is_fetch;
        m_losses = n_losses;
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_inputs();
        if_req = 0; if_addr = 0;
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_be = 0;
        mem_rvalid = 0; mem_rdata = 0;
    endtask

    // One memory response cycle with the given data, then quiet memory input.
    task automatic respond(input logic [31:0] data);
        mem_rvalid = 1;
        mem_rdata = data;
        settle();
        advance();
        mem_rvalid = 0;
    endtask

    initial begin
        reset = 1;
        quiet_inputs();
        m_outstanding = 0; m_owner_is_fetch = 0; m_losses = 0;
        mem_cnt = 0;
        @(posedge clk);
        #1;

        // Reset held with every input active: all outputs must stay zero.
        if_req = 1; if_addr = 32'h40; d_req = 1; d_addr = 32'h80;
        mem_rvalid = 1; mem_rdata = 32'h12345678;
        settle();
        check("rst mem_req", 32'(mem_req), 0);
        check("rst if_gnt", 32'(if_gnt), 0);
        check("rst d_gnt", 32'(d_gnt), 0);
        check("rst if_rvalid", 32'(if_rvalid), 0);
        check("rst d_rvalid", 32'(d_rvalid), 0);
        check("rst if_rdata", if_rdata, 0);
        check("rst d_rdata", d_rdata, 0);
        advance();
        reset = 0;
        quiet_inputs();

        // Single fetch with 1-cycle memory.
        if_req = 1; if_addr = 32'h100;
        settle();
        check("t1 if_gnt", 32'(if_gnt), 1);
        check("t1 mem_req", 32'(mem_req), 1);
        check("t1 mem_addr", mem_addr, 32'h100);
        check("t1 mem_be", 32'(mem_be), 32'hF);
        check("t1 mem_we", 32'(mem_we), 0);
        advance();
        if_req = 0;
        mem_rvalid = 1; mem_rdata = 32'h00000013;
        settle();
        check("t1 if_rvalid", 32'(if_rvalid), 1);
        check("t1 if_rdata", if_rdata, 32'h00000013);
        check("t1 d_rvalid", 32'(d_rvalid), 0);
        advance();
        mem_rvalid = 0;
        if_req = 1; if_addr = 32'h104;
        settle();
        check("t1 idle again", 32'(if_gnt), 1);
        advance();
        if_req = 0;
        respond(32'h1);

        // Simultaneous requests: store goes first, fetch follows.
        if_req = 1; if_addr = 32'h108;
        d_req = 1; d_we = 1; d_addr = 32'h200; d_wdata = 32'hDEADBEEF; d_be = 4'b0011;
        settle();
        check("t2 d_gnt", 32'(d_gnt), 1);
        check("t2 if_gnt", 32'(if_gnt), 0);
        check("t2 mem_we", 32'(mem_we), 1);
        check("t2 mem_be", 32'(mem_be), 32'h3);
        check("t2 mem_wdata", mem_wdata, 32'hDEADBEEF);
        check("t2 mem_addr", mem_addr, 32'h200);
        advance();
        d_req = 0;
        mem_rvalid = 1; mem_rdata = 32'h0;
        settle();
        check("t2 d_rvalid", 32'(d_rvalid), 1);
        check("t2 if_gnt busy", 32'(if_gnt), 0);
        advance();
        mem_rvalid = 0;
        settle();
        check("t2 if_gnt next", 32'(if_gnt), 1);
        check("t2 if mem_addr", mem_addr, 32'h108);
        advance();
        if_req = 0;
        respond(32'h2);

        // Starvation: both held; D, D, D, D, then IF, then D again.
        if_req = 1; if_addr = 32'h10C;
        d_req = 1; d_we = 0; d_addr = 32'h300; d_wdata = 0; d_be = 4'hF;
        for (int g = 0; g < 6; g++) begin
            settle();
            check("t3 if_gnt", 32'(if_gnt), (g == 4) ? 32'd1 : 32'd0);
            check("t3 d_gnt", 32'(d_gnt), (g == 4) ? 32'd0 : 32'd1);
            advance();
            respond(32'h100 + 32'(g));
        end
        quiet_inputs();

        // Variable latency: load waits 5 cycles, fetch blocked until after it.
        d_req = 1; d_we = 0; d_addr = 32'h400; d_be = 4'hF;
        settle();
        check("t4 d_gnt", 32'(d_gnt), 1);
        advance();
        d_req = 0;
        if_req = 1; if_addr = 32'h110;
        for (int k = 1; k < 5; k++) begin
            settle();
            check("t4 if_gnt wait", 32'(if_gnt), 0);
            check("t4 mem_req wait", 32'(mem_req), 0);
            advance();
        end
        mem_rvalid = 1; mem_rdata = 32'hCAFEF00D;
        settle();
        check("t4 d_rvalid", 32'(d_rvalid), 1);
        check("t4 d_rdata", d_rdata, 32'hCAFEF00D);
        check("t4 if_gnt resp", 32'(if_gnt), 0);
        check("t4 if_rvalid", 32'(if_rvalid), 0);
        advance();
        mem_rvalid = 0;
        settle();
        check("t4 if_gnt after", 32'(if_gnt), 1);
        advance();
        if_req = 0;
        respond(32'h3);

        // Reset mid-transaction: the late response is dropped.
        if_req = 1; if_addr = 32'h114;
        settle();
        check("t5 if_gnt", 32'(if_gnt), 1);
        advance();
        if_req = 0;
        reset = 1; d_req = 1; d_addr = 32'h500;
        settle();
        check("t5 rst mem_req", 32'(mem_req), 0);
        check("t5 rst d_gnt", 32'(d_gnt), 0);
        advance();
        reset = 0; d_req = 0;
        mem_rvalid = 1; mem_rdata = 32'h55AA55AA;
        settle();
        check("t5 if_rvalid", 32'(if_rvalid), 0);
        check("t5 d_rvalid", 32'(d_rvalid), 0);
        check("t5 if_rdata", if_rdata, 0);
        advance();
        mem_rvalid = 0;

        // Stray response while idle.
        mem_rvalid = 1; mem_rdata = 32'hFFFFFFFF;
        settle();
        check("t6 if_rvalid", 32'(if_rvalid), 0);
        check("t6 d_rvalid", 32'(d_rvalid), 0);
        check("t6 mem_req", 32'(mem_req), 0);
        advance();
        mem_rvalid = 0;
        d_req = 1; d_we = 1; d_addr = 32'h600; d_wdata = 32'h0BADF00D; d_be = 4'b1100;
        settle();
        check("t6 still idle", 32'(d_gnt), 1);
        advance();
        d_req = 0;
        respond(32'h4);
        quiet_inputs();

        // Randomized traffic: requesters hold until granted (or drop early),
        // memory answers 1..5 cycles after each request, with stray responses
        // and occasional resets.
        mem_cnt = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            reset = ($urandom_range(0, 149) == 0);
            mem_rvalid = 0;
            mem_rdata = $urandom;
            if (reset) begin
                mem_cnt = 0;
            end else if (mem_cnt > 0) begin
                mem_cnt--;
                if (mem_cnt == 0) mem_rvalid = 1;
            end else if ($urandom_range(0, 19) == 0) begin
                mem_rvalid = 1;
            end
            if (e_if_gnt || (if_req && $urandom_range(0, 15) == 0)) begin
                if_req = 0;
            end else if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req = 1;
                if_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (e_d_gnt || (d_req && $urandom_range(0, 15) == 0)) begin
                d_req = 0;
            end else if (!d_req && $urandom_range(0, 2) == 0) begin
                d_req = 1;
                d_we = 1'($urandom);
                d_addr = $urandom;
                d_wdata = $urandom;
                d_be = 4'($urandom);
            end
            settle();
            if (e_mem_req) mem_cnt = $urandom_range(1, 5);
            advance();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
